// File: rtl/piezo_led_arbiter.sv
// piezo_led_arbiter: shares one piezo/LED note output between ending music,
// question auto-play and live key tones. Fixed priority, ending music can
// preempt, a silent gap separates owners, and over-long owners are revoked.
module piezo_led_arbiter #(
    parameter int TICK_MAX      = 5000000,
    parameter int GAP_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] req,
    input  logic [3:0] note0,
    input  logic [3:0] note1,
    input  logic [3:0] note2,
    output logic [2:0] grant,
    output logic [3:0] piezo_out,
    output logic [3:0] led_out,
    output logic       busy,
    output logic       timeout
);

    // Ticker width covers 0..TICK_MAX; a degenerate TICK_MAX of 0 still needs one bit.
    localparam int TW      = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    // One shared tick counter serves both the ownership timeout and the gap.
    localparam int CNT_MAX = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int CW      = $clog2(CNT_MAX + 2);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [CW-1:0] TO_LAST   = CW'((TIMEOUT_TICKS > 0) ? TIMEOUT_TICKS - 1 : 0);
    localparam logic          GAP_EN    = (GAP_TICKS > 0);
    localparam logic          TO_EN     = (TIMEOUT_TICKS > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_ticker;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_lockout;
    logic [2:0]      r_grant;
    logic [3:0]      r_piezo;
    logic            r_timeout;

    state_t          w_stateNext;
    logic [CW-1:0]   w_cntNext;
    logic [2:0]      w_grantNext;
    logic [3:0]      w_piezoNext;
    logic            w_timeoutNext;
    logic [2:0]      w_lockSet;

    logic            w_tick;
    logic [2:0]      w_eligible;
    logic            w_release;
    logic            w_preempt;
    logic            w_revoke;
    logic [3:0]      w_ownerNote;

    assign w_tick      = (r_ticker == TICK_LAST);
    assign w_eligible  = req & ~r_lockout;
    assign w_release   = ~|(req & r_grant);
    assign w_preempt   = w_eligible[2] & ~r_grant[2];
    assign w_revoke    = TO_EN & w_tick & (r_cnt == TO_LAST);
    assign w_ownerNote = r_grant[2] ? note2 : (r_grant[1] ? note1 : note0);

    assign grant     = r_grant;
    assign piezo_out = r_piezo;
    assign led_out   = r_piezo;
    assign busy      = (r_state != IDLE);
    assign timeout   = r_timeout;

    // Free-running tick prescaler; deliberately never cleared by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ticker <= '0;
        end else if (w_tick) begin
            r_ticker <= '0;
        end else begin
            r_ticker <= r_ticker + 1'b1;
        end
    end

    // Lockout holds a revoked requester off until it lets go of its request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lockout <= '0;
        end else begin
            r_lockout <= (r_lockout | w_lockSet) & req;
        end
    end

    // State and registered outputs of the arbitration FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_piezo   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_cnt     <= w_cntNext;
            r_grant   <= w_grantNext;
            r_piezo   <= w_piezoNext;
            r_timeout <= w_timeoutNext;
        end
    end

    // Next state and outputs; release is tested before revoke so a voluntary
    // drop on the timeout tick is never punished, and revoke before preempt.
    always_comb begin
        w_stateNext   = r_state;
        w_cntNext     = r_cnt;
        w_grantNext   = r_grant;
        w_piezoNext   = r_piezo;
        w_timeoutNext = 1'b0;
        w_lockSet     = '0;
        case (r_state)
            IDLE: begin
                w_grantNext = '0;
                w_piezoNext = '0;
                w_cntNext   = '0;
                if (w_eligible[2]) begin
                    w_stateNext = GRANT;
                    w_grantNext = 3'b100;
                    w_piezoNext = note2;
                end else if (w_eligible[1]) begin
                    w_stateNext = GRANT;
                    w_grantNext = 3'b010;
                    w_piezoNext = note1;
                end else if (w_eligible[0]) begin
                    w_stateNext = GRANT;
                    w_grantNext = 3'b001;
                    w_piezoNext = note0;
                end
            end
            GRANT: begin
                if (w_release || w_revoke || w_preempt) begin
                    w_stateNext = GAP;
                    w_grantNext = '0;
                    w_piezoNext = '0;
                    w_cntNext   = '0;
                    if (!w_release && w_revoke) begin
                        w_timeoutNext = 1'b1;
                        w_lockSet     = r_grant;
                    end
                end else begin
                    w_piezoNext = w_ownerNote;
                    if (w_tick) begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                w_grantNext = '0;
                w_piezoNext = '0;
                if (!GAP_EN) begin
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else if (w_tick) begin
                    if (r_cnt == GAP_LAST) begin
                        w_stateNext = IDLE;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = IDLE;
                w_grantNext = '0;
                w_piezoNext = '0;
                w_cntNext   = '0;
            end
        endcase
    end

endmodule

// File: doc/piezo_led_arbiter.md
# piezo_led_arbiter

Shares the single piezo/LED output pair between three note sources: ending music, question auto-play and live key tones. It sits between those sources and the board piezo/LED pins. The block grants ownership with fixed priority and lets ending music preempt the other sources. It inserts a silent gap between owners and force-revokes any owner that holds the output too long.

## Interface
- TICK_MAX, 5000000: ticker terminal count; tick period is TICK_MAX+1 cycles.
- GAP_TICKS, 2: silent tick periods between owners; 0 means a one-cycle gap.
- TIMEOUT_TICKS, 100: maximum ownership in ticks; 0 disables the timeout.

- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- req  in  3  ownership requests: bit2 ending music, bit1 auto-play, bit0 key tone; level-held.
- note0, note1, note2  in  4 each  note code of requester i; 0 = silence.
- grant  out  3  one-hot current owner; 0 when no owner.
- piezo_out  out  4  note code to piezo.
- led_out  out  4  equals piezo_out.
- busy  out  1  high when state is not IDLE.
- timeout  out  1  one-cycle pulse on forced revoke.

## Operation
- Ticker:
  - free-running counter 0..TICK_MAX, width ceil(log2(TICK_MAX+1)), 23 bits at default.
  - tick = (ticker == TICK_MAX); wraps to 0 on the next edge.
- Lockout: per-requester bit.
  - Set on timeout of that owner.
  - Cleared on any edge where that requester's req is 0.
  - Eligible requests are req & ~lockout.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any request is eligible, go to GRANT and grant the highest index.
  - grant and piezo_out are loaded at the same edge.
- GRANT:
  - piezo_out follows note[owner] each edge.
  - Timeout counter counts tick pulses from 0.
  - Exit to GAP when any one of these holds:
    - req[owner]=0 (release);
    - owner≠2 and req[2] is eligible (preempt);
    - counter reaches TIMEOUT_TICKS (revoke): pulse timeout, set lockout[owner].
  - On GAP entry, grant and piezo_out go to 0.
- GAP:
  - Outputs stay 0.
  - Count tick pulses and go to IDLE when the count reaches GAP_TICKS.
  - With GAP_TICKS=0, go to IDLE on the next edge.
- Arbitration happens only in IDLE. A request that arrives in GAP waits; no request is lost while it is held.
- Simultaneous events:
  - Release and timeout in the same cycle: release wins; no pulse, no lockout.
  - Timeout and preempt in the same cycle: timeout wins; pulse and lockout apply.
- Reset, asserted at any time:
  - state IDLE; ticker, counters and lockouts cleared.
  - grant, piezo_out, led_out, busy and timeout all 0.

## Timing
- Request to grant: req eligible in IDLE at edge N gives grant and piezo_out valid after edge N.
- Note change while owned: visible on piezo_out one cycle later.
- Release: req low sampled at edge N gives grant=0 and piezo_out=0 after edge N.
- Minimum silence between owners is GAP_TICKS full tick periods minus up to one period of phase (ticker is not reset), plus one IDLE cycle.
- timeout is high for exactly one cycle, coincident with grant dropping to 0.
- grant is always one-hot or zero; piezo_out is 0 whenever grant is 0.

## Test plan
Parameters for all scenarios: TICK_MAX=9, GAP_TICKS=2, TIMEOUT_TICKS=3.

- Reset: hold reset=0 with req=3'b111 and notes nonzero.
  - Required: every output 0 throughout.
  - After release: IDLE, then grant=3'b100 on the first edge.
- Priority and note: req=3'b011, note1=5, note0=2.
  - Required: grant=3'b010 and piezo_out=led_out=5 one edge later.
  - note1 changed to 7 gives piezo_out=7 next cycle.
- Release and gap: owner 1 drops req while req[0]=1.
  - Required: grant=0 and piezo_out=0 next edge.
  - grant=3'b001 only after 2 tick pulses plus one IDLE cycle.
- Preemption: owner 0 (note0=3), then raise req[2] with note2=8.
  - Required: grant=0 next edge, GAP, then grant=3'b100 and piezo_out=8.
- Timeout and lockout: hold req[1] high for more than 3 ticks.
  - Required: timeout pulses 1 cycle on the 3rd tick and grant drops to 0.
  - No regrant of bit1 while req[1] stays high.
  - After req[1] drops for 1 cycle and rises again, bit1 is granted after the gap.
- Simultaneous: req[owner] falls on the same edge the 3rd tick is counted.
  - Required: timeout stays 0 and no lockout, so an immediate re-request is granted after the gap.
